// File: rtl/divider_pipe_if.sv
// divider_pipe_if: request/result valid-ready channels of divider_pipe
interface divider_pipe_if #(
  parameter int N     = 39,
  parameter int M     = 30,
  parameter int TAG_W = 4
);
  logic             in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [N-1:0]     dividend, quotient;
  logic [M-1:0]     divisor, remainder;
  logic [TAG_W-1:0] in_tag, out_tag;
  modport master (
    output in_valid, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, out_tag
  );
  modport slave (
    input  in_valid, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, out_tag
  );
endinterface

// File: rtl/divider_pipe.sv
// divider_pipe: fully pipelined radix-2 restoring divider, one quotient bit per stage
module divider_pipe #(
  parameter int N      = 39,
  parameter int M      = 30,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input logic            clk,
  input logic            rstn,
  divider_pipe_if.slave  bus
);
  logic             w_en, w_na, w_nb;
  logic [N-1:0]     w_a, w_q;
  logic [M-1:0]     w_b, w_r;
  logic             r_v   [0:N];
  logic [M-1:0]     r_rem [0:N];
  logic [N-1:0]     r_aq  [0:N];
  logic [M-1:0]     r_b   [0:N-1];
  logic             r_sq  [0:N];
  logic             r_sr  [0:N];
  logic             r_dz  [0:N];
  logic [TAG_W-1:0] r_tag [0:N];
  logic [M-1:0]     w_rem [0:N-1];
  logic             w_qb  [0:N-1];
  assign w_en        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_en;
  assign w_na = (SIGNED != 0) && bus.dividend[N-1];
  assign w_nb = (SIGNED != 0) && bus.divisor[M-1];
  assign w_a  = w_na ? -bus.dividend : bus.dividend;
  assign w_b  = w_nb ? -bus.divisor : bus.divisor;
  // r_aq holds the not-yet-consumed dividend bits on top and the quotient bits filling in below
  for (genvar k = 0; k < N; k++) begin : g_st
    logic [M:0] w_x;
    logic       w_ge;
    assign w_x      = {r_rem[k], r_aq[k][N-1]};
    assign w_ge     = w_x >= {1'b0, r_b[k]};
    assign w_qb[k]  = w_ge;
    assign w_rem[k] = w_ge ? w_x[M-1:0] - r_b[k] : w_x[M-1:0];
  end
  assign w_q = r_sq[N] ? -r_aq[N] : r_aq[N];
  assign w_r = r_sr[N] ? -r_rem[N] : r_rem[N];
  always_ff @(posedge clk)
    if (w_en) begin
      r_rem[0] <= '0;
      r_aq[0]  <= w_a;
      r_b[0]   <= w_b;
      r_sq[0]  <= w_na ^ w_nb;
      r_sr[0]  <= w_na;
      r_dz[0]  <= bus.divisor == '0;
      r_tag[0] <= bus.in_tag;
      for (int i = 1; i <= N; i++) begin
        r_rem[i] <= w_rem[i-1];
        r_aq[i]  <= {r_aq[i-1][N-2:0], w_qb[i-1]};
        r_sq[i]  <= r_sq[i-1];
        r_sr[i]  <= r_sr[i-1];
        r_dz[i]  <= r_dz[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      for (int i = 1; i < N; i++) r_b[i] <= r_b[i-1];
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i <= N; i++) r_v[i] <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.out_tag     <= '0;
    end else if (w_en) begin
      r_v[0] <= bus.in_valid;
      for (int i = 1; i <= N; i++) r_v[i] <= r_v[i-1];
      bus.out_valid   <= r_v[N];
      bus.quotient    <= r_dz[N] ? '1 : w_q;
      bus.remainder   <= r_dz[N] ? '0 : w_r;
      bus.div_by_zero <= r_dz[N];
      bus.out_tag     <= r_tag[N];
    end
endmodule

// File: tb/tb_divider_pipe.sv
// tb_divider_pipe: unsigned and signed divider_pipe side by side against a table and an arithmetic model
module tb_divider_pipe;
  localparam int N = 39, M = 30, TAG_W = 4;
  typedef struct packed {
    logic [N-1:0]     q;
    logic [M-1:0]     r;
    logic             dz;
    logic [TAG_W-1:0] tag;
  } res_t;
  typedef struct {
    logic [N-1:0]     a;
    logic [M-1:0]     b;
    logic [TAG_W-1:0] t;
    res_t             e0;
    res_t             e1;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic [TAG_W-1:0] in_tag = '0;
  res_t cur_e0, cur_e1;
  res_t exp0[$], exp1[$];
  bit hold[2];
  logic [$bits(res_t):0] held[2];
  int rcv[2];
  int n_vec = 0, n_err = 0;
  bit done;
  vec_t tbl[10];
  divider_pipe_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus0 ();
  divider_pipe_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus1 ();
  assign bus0.in_valid = in_valid;
  assign bus0.dividend = dividend;
  assign bus0.divisor = divisor;
  assign bus0.in_tag = in_tag;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;
  assign bus1.dividend = dividend;
  assign bus1.divisor = divisor;
  assign bus1.in_tag = in_tag;
  assign bus1.out_ready = out_ready;
  divider_pipe #(.N(N), .M(M), .SIGNED(0), .TAG_W(TAG_W)) u0 (.clk(clk), .rstn(rstn), .bus(bus0));
  divider_pipe #(.N(N), .M(M), .SIGNED(1), .TAG_W(TAG_W)) u1 (.clk(clk), .rstn(rstn), .bus(bus1));
  always #5 clk = ~clk;
  function automatic res_t mk(input logic [N-1:0] q, input logic [M-1:0] r, input logic dz, input logic [TAG_W-1:0] t);
    return {q, r, dz, t};
  endfunction
  function automatic res_t model(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAG_W-1:0] t, input bit sgn);
    longint x, y, q, r;
    if (b == '0) return {{N{1'b1}}, {M{1'b0}}, 1'b1, t};
    x = sgn ? longint'($signed(a)) : longint'(a);
    y = sgn ? longint'($signed(b)) : longint'(b);
    q = x / y;
    r = x % y;
    return {q[N-1:0], r[M-1:0], 1'b0, t};
  endfunction
  task automatic chk(input int id, input logic ov, input logic ordy, input res_t act);
    res_t e;
    if (hold[id]) begin
      n_vec++;
      if ({ov, act} !== held[id]) begin
        n_err++;
        $display("FAIL stable dut%0d: got %h, held %h", id, {ov, act}, held[id]);
      end
    end
    hold[id] = ov && !ordy;
    held[id] = {ov, act};
    if (ov && ordy) begin
      n_vec++;
      rcv[id]++;
      if ((id == 0 ? exp0.size() : exp1.size()) == 0) begin
        n_err++;
        $display("FAIL unexpected dut%0d: result %h with none outstanding", id, act);
      end else begin
        if (id == 0) e = exp0.pop_front();
        else e = exp1.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL result dut%0d: got q=%h r=%h dz=%b tag=%h, want q=%h r=%h dz=%b tag=%h",
                   id, act.q, act.r, act.dz, act.tag, e.q, e.r, e.dz, e.tag);
        end
      end
    end
  endtask
  always @(negedge clk)
    if (rstn) begin
      chk(0, bus0.out_valid, out_ready, {bus0.quotient, bus0.remainder, bus0.div_by_zero, bus0.out_tag});
      chk(1, bus1.out_valid, out_ready, {bus1.quotient, bus1.remainder, bus1.div_by_zero, bus1.out_tag});
      if (in_valid && bus0.in_ready) exp0.push_back(cur_e0);
      if (in_valid && bus1.in_ready) exp1.push_back(cur_e1);
    end
  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAG_W-1:0] t, input res_t e0, input res_t e1);
    int w = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    in_tag = t;
    cur_e0 = e0;
    cur_e1 = e1;
    @(negedge clk);
    while (!bus0.in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!bus0.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: in_ready still %b after %0d cycles", bus0.in_ready, w);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_m(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAG_W-1:0] t);
    send(a, b, t, model(a, b, t, 1'b0), model(a, b, t, 1'b1));
  endtask
  task automatic drain();
    int w = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && w < 2000) begin
      @(posedge clk);
      w++;
    end
    #1;
    n_vec++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d results outstanding, want 0", exp0.size(), exp1.size());
    end
  endtask
  task automatic lat(input vec_t v);
    int c = 1;
    send(v.a, v.b, v.t, v.e0, v.e1);
    while (!bus0.out_valid && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    n_vec++;
    if (c != N + 2 || !bus1.out_valid) begin
      n_err++;
      $display("FAIL latency: out_valid after %0d cycles (signed dut %b), want %0d", c, bus1.out_valid, N + 2);
    end
    @(posedge clk);
    #1 n_vec++;
    if (bus0.out_valid || bus1.out_valid) begin
      n_err++;
      $display("FAIL trailing: out_valid %b/%b after single result, want 0", bus0.out_valid, bus1.out_valid);
    end
  endtask
  task automatic rst_chk();
    n_vec++;
    if ({bus0.out_valid, bus0.quotient, bus0.remainder, bus0.div_by_zero, bus0.out_tag,
         bus1.out_valid, bus1.quotient, bus1.remainder, bus1.div_by_zero, bus1.out_tag} !== '0) begin
      n_err++;
      $display("FAIL reset: outputs %b %h %h %b %h / %b %h %h %b %h, want all 0",
               bus0.out_valid, bus0.quotient, bus0.remainder, bus0.div_by_zero, bus0.out_tag,
               bus1.out_valid, bus1.quotient, bus1.remainder, bus1.div_by_zero, bus1.out_tag);
    end
  endtask
  function automatic logic [N-1:0] rnd_a();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return ($urandom_range(0, 9) == 0) ? {1'b1, {(N-1){1'b0}}} : x[N-1:0];
  endfunction
  function automatic logic [M-1:0] rnd_b();
    logic [31:0] x;
    int s;
    x = $urandom();
    s = $urandom_range(0, 7);
    if (s == 0) return '0;
    if (s < 3) return M'($urandom_range(1, 15));
    if (s == 3) return '1;
    return x[M-1:0];
  endfunction
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{39'd1000, 30'd7, 4'd3, mk(39'd142, 30'd6, 1'b0, 4'd3), mk(39'd142, 30'd6, 1'b0, 4'd3)};
    tbl[1] = '{39'd12345, 30'd0, 4'd1, mk('1, '0, 1'b1, 4'd1), mk('1, '0, 1'b1, 4'd1)};
    tbl[2] = '{39'd549755813881, 30'd2, 4'd2, mk(39'd274877906940, 30'd1, 1'b0, 4'd2), mk(39'd549755813885, 30'd1073741823, 1'b0, 4'd2)};
    tbl[3] = '{39'd7, 30'd1073741822, 4'd4, mk(39'd0, 30'd7, 1'b0, 4'd4), mk(39'd549755813885, 30'd1, 1'b0, 4'd4)};
    tbl[4] = '{39'd274877906944, 30'd1073741823, 4'd5, mk(39'd256, 30'd256, 1'b0, 4'd5), mk(39'd274877906944, 30'd0, 1'b0, 4'd5)};
    tbl[5] = '{39'd274877906944, 30'd3, 4'd6, mk(39'd91625968981, 30'd1, 1'b0, 4'd6), mk(39'd458129844907, 30'd1073741823, 1'b0, 4'd6)};
    tbl[6] = '{39'd549755813887, 30'd1, 4'd7, mk(39'd549755813887, 30'd0, 1'b0, 4'd7), mk('1, 30'd0, 1'b0, 4'd7)};
    tbl[7] = '{39'd0, 30'd5, 4'd8, mk(39'd0, 30'd0, 1'b0, 4'd8), mk(39'd0, 30'd0, 1'b0, 4'd8)};
    tbl[8] = '{39'd100, 30'd0, 4'd9, mk('1, '0, 1'b1, 4'd9), mk('1, '0, 1'b1, 4'd9)};
    tbl[9] = '{39'd549755813887, 30'd1073741823, 4'd10, mk(39'd512, 30'd511, 1'b0, 4'd10), mk(39'd1, 30'd0, 1'b0, 4'd10)};
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_chk();
    @(posedge clk);
    #1 rstn = 1'b1;
    lat(tbl[0]);
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].t, tbl[i].e0, tbl[i].e1);
    drain();
    rcv[0] = 0;
    rcv[1] = 0;
    fork
      for (int k = 0; k < 64; k++)
        send_m(N'(39'h3F_FFFF_FFFF - k), M'(4096 + 13 * k), TAG_W'(k % 16));
      begin
        repeat (50) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_vec++;
          if (bus0.in_ready || bus1.in_ready || !bus0.out_valid) begin
            n_err++;
            $display("FAIL backpressure: in_ready %b/%b out_valid %b, want 0/0 and 1",
                     bus0.in_ready, bus1.in_ready, bus0.out_valid);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (rcv[0] != 64 || rcv[1] != 64) begin
      n_err++;
      $display("FAIL stream count: got %0d/%0d results, want 64", rcv[0], rcv[1]);
    end
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_m(rnd_a(), rnd_b(), TAG_W'($urandom()));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    fork
      for (int k = 0; k < 10; k++) send_m(rnd_a(), rnd_b(), TAG_W'(k));
      begin
        repeat (20) @(posedge clk);
        #1 rstn = 1'b0;
        #1 rst_chk();
        exp0.delete();
        exp1.delete();
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
      end
    join
    repeat (60) begin
      @(negedge clk);
      n_vec++;
      if (bus0.out_valid || bus1.out_valid) begin
        n_err++;
        $display("FAIL ghost: out_valid %b/%b after reset, want 0", bus0.out_valid, bus1.out_valid);
      end
    end
    @(posedge clk);
    #1 lat(tbl[2]);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
